// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 size codes,
// FSM states and the alignment predicate.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    // Unlisted funct3 codes fall back to a full word access.
    function automatic mem_size_e size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (size_of(f3))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-mask/data replication and load
// lane extraction with sign or zero extension.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    mem_size_e   w_size;
    logic        w_unsigned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_size     = size_of(i_funct3);
        w_unsigned = is_unsigned(i_funct3);

        case (w_size)
            SZ_BYTE: begin
                o_mask  = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            SZ_HALF: begin
                o_mask  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                o_mask  = 4'b1111;
                o_wdata = i_store_data;
            end
        endcase

        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (w_size)
            SZ_BYTE: o_load_data = w_unsigned ? {24'd0, w_byte}
                                              : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = w_unsigned ? {16'd0, w_half}
                                              : {{16{w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory requests, stalls the pipeline
// until each access completes and flags misalignment and bus timeouts.
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_dmem_req,
    input  logic        i_dmem_ready,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_wen,
    output logic        o_dmem_ren,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_mem_data_out,
    output logic [31:0] o_dmem_rdata,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam int unsigned      CNT_W     = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    lsu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [2:0]       r_funct3;
    logic [31:0]      r_store_data;
    logic             r_is_load;

    logic        w_idle;
    logic        w_mem_op;
    logic        w_misal;
    logic        w_issue;
    logic        w_timeout;
    logic        w_accept;
    logic        w_load_done;
    logic        w_req;
    logic        w_busy;
    logic        w_valid;
    logic        w_is_load;
    logic [31:0] w_sel_addr;
    logic [2:0]  w_sel_funct3;
    logic [31:0] w_sel_sdata;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    // In IDLE the request comes straight from EX/MEM; once issued it is
    // served from the snapshot so the bus fields cannot move under REQ.
    assign w_idle       = (r_state == IDLE);
    assign w_sel_addr   = w_idle ? i_addr       : r_addr;
    assign w_sel_funct3 = w_idle ? i_funct3     : r_funct3;
    assign w_sel_sdata  = w_idle ? i_store_data : r_store_data;
    assign w_is_load    = w_idle ? i_mem_read   : r_is_load;

    assign w_mem_op    = i_valid && (i_mem_read || i_mem_write);
    assign w_misal     = w_idle && w_mem_op && is_misaligned(i_funct3, i_addr[1:0]);
    assign w_issue     = w_idle && w_mem_op && !w_misal;
    assign w_load_done = (r_state == WAIT) && i_dmem_rvalid;
    assign w_timeout   = !w_idle && (r_cnt >= CNT_LIMIT) && !w_load_done;
    assign w_accept    = !w_timeout && i_dmem_ready && (w_issue || (r_state == REQ));
    assign w_req       = w_issue || ((r_state == REQ) && !w_timeout);
    assign w_busy      = w_issue || !w_idle;

    always_comb begin
        w_valid = 1'b0;
        case (r_state)
            IDLE:    w_valid = i_valid && (!w_mem_op || w_misal || (w_accept && !i_mem_read));
            REQ:     w_valid = w_timeout || (w_accept && !r_is_load);
            WAIT:    w_valid = w_load_done || w_timeout;
            default: w_valid = 1'b0;
        endcase
    end

    lsu_align u_align (
        .i_funct3     (w_sel_funct3),
        .i_addr_lo    (w_sel_addr[1:0]),
        .i_store_data (w_sel_sdata),
        .i_rdata      (i_dmem_rdata),
        .o_mask       (w_mask),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_store_data <= '0;
            r_is_load    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_issue) begin
                        r_addr       <= i_addr;
                        r_funct3     <= i_funct3;
                        r_store_data <= i_store_data;
                        r_is_load    <= i_mem_read;
                        if (!w_accept) begin
                            r_state <= REQ;
                            r_cnt   <= CNT_ONE;
                        end else if (i_mem_read) begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                REQ: begin
                    if (w_timeout || (w_accept && !r_is_load)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        if (w_accept) r_state <= WAIT;
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                WAIT: begin
                    if (w_load_done || w_timeout) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Everything is gated by reset so an abandoned access leaves no trace
    // on the outputs while i_rst is low.
    always_comb begin
        o_dmem_req     = 1'b0;
        o_dmem_addr    = '0;
        o_dmem_wen     = 1'b0;
        o_dmem_ren     = 1'b0;
        o_dmem_mask    = '0;
        o_dmem_wdata   = '0;
        o_stall        = 1'b0;
        o_valid        = 1'b0;
        o_mem_data_out = '0;
        o_dmem_rdata   = '0;
        o_misaligned   = 1'b0;
        o_bus_err      = 1'b0;
        if (i_rst) begin
            o_dmem_req   = w_req;
            o_valid      = w_valid;
            o_stall      = w_busy && !w_valid;
            o_misaligned = w_misal;
            o_bus_err    = w_timeout;
            if (w_req) begin
                o_dmem_addr  = {w_sel_addr[31:2], 2'b00};
                o_dmem_wen   = !w_is_load;
                o_dmem_ren   = w_is_load;
                o_dmem_mask  = w_mask;
                o_dmem_wdata = w_is_load ? 32'd0 : w_wdata;
            end
            if (w_load_done) begin
                o_mem_data_out = w_load_data;
                o_dmem_rdata   = i_dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu with a reduced timeout limit.
module tb_mem_stage_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        o_dmem_req;
    logic        i_dmem_ready;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_wen;
    logic        o_dmem_ren;
    logic [3:0]  o_dmem_mask;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_mem_data_out;
    logic [31:0] o_dmem_rdata;
    logic        o_misaligned;
    logic        o_bus_err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 i_clk = ~i_clk;

    mem_stage_lsu #(.WAIT_LIMIT(8)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_funct3       (i_funct3),
        .i_addr         (i_addr),
        .i_store_data   (i_store_data),
        .o_dmem_req     (o_dmem_req),
        .i_dmem_ready   (i_dmem_ready),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_wen     (o_dmem_wen),
        .o_dmem_ren     (o_dmem_ren),
        .o_dmem_mask    (o_dmem_mask),
        .o_dmem_wdata   (o_dmem_wdata),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_stall        (o_stall),
        .o_valid        (o_valid),
        .o_mem_data_out (o_mem_data_out),
        .o_dmem_rdata   (o_dmem_rdata),
        .o_misaligned   (o_misaligned),
        .o_bus_err      (o_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_valid       = 1'b0;
        i_mem_read    = 1'b0;
        i_mem_write   = 1'b0;
        i_funct3      = 3'b010;
        i_addr        = '0;
        i_store_data  = '0;
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = '0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one access, models the memory (ready low for ready_low cycles,
    // rvalid rsp_delay cycles after accept) and checks fields, stalls and result.
    task automatic do_access(input string tag, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input int ready_low, input int rsp_delay,
                             input logic [31:0] rdata, input logic [3:0] exp_mask,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                             input int exp_stalls);
        int          stalls   = 0;
        int          acc      = -1;
        bit          done     = 0;
        bit          seen_req = 0;
        bit          hold_bad = 0;
        logic [31:0] f_addr   = '0;
        logic [3:0]  f_mask   = '0;
        logic [31:0] f_wdata  = '0;
        i_valid       = 1'b1;
        i_mem_read    = !wr;
        i_mem_write   = wr;
        i_funct3      = f3;
        i_addr        = addr;
        i_store_data  = sdata;
        i_dmem_ready  = (ready_low == 0);
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge i_clk);
            if (o_dmem_req) begin
                if (!seen_req) begin
                    seen_req = 1;
                    f_addr   = o_dmem_addr;
                    f_mask   = o_dmem_mask;
                    f_wdata  = o_dmem_wdata;
                    chk({tag, " addr"},  o_dmem_addr, {addr[31:2], 2'b00});
                    chk({tag, " mask"},  {28'd0, o_dmem_mask}, {28'd0, exp_mask});
                    chk({tag, " wdata"}, o_dmem_wdata, exp_wdata);
                    chk({tag, " wen/ren"}, {30'd0, o_dmem_wen, o_dmem_ren}, {30'd0, wr, !wr});
                end else if (o_dmem_addr !== f_addr || o_dmem_mask !== f_mask ||
                             o_dmem_wdata !== f_wdata) begin
                    hold_bad = 1;
                end
                if (i_dmem_ready) acc = cyc;
            end
            if (o_valid) begin
                done = 1;
                chk({tag, " data"},   o_mem_data_out, exp_data);
                chk({tag, " rdtrace"}, o_dmem_rdata, wr ? 32'd0 : rdata);
                chk({tag, " buserr"}, {31'd0, o_bus_err}, 32'd0);
                break;
            end
            if (o_stall) stalls++;
            next_cycle();
            i_dmem_ready  = (cyc + 1 >= ready_low);
            i_dmem_rvalid = (acc >= 0) && (cyc + 1 == acc + rsp_delay);
            i_dmem_rdata  = i_dmem_rvalid ? rdata : 32'd0;
        end
        chk({tag, " done"},   {31'd0, done}, 32'd1);
        chk({tag, " stalls"}, stalls, exp_stalls);
        chk({tag, " hold"},   {31'd0, hold_bad}, 32'd0);
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        i_rst       = 1'b0;
        i_valid     = 1'b1;
        i_mem_read  = 1'b1;
        i_dmem_ready = 1'b1;
        @(negedge i_clk);
        chk("rst req",   {31'd0, o_dmem_req}, 32'd0);
        chk("rst stall", {31'd0, o_stall}, 32'd0);
        chk("rst valid", {31'd0, o_valid}, 32'd0);
        next_cycle();
        idle_inputs();
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("idle valid", {31'd0, o_valid}, 32'd0);
        next_cycle();

        do_access("SW",  1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 32'h0,
                  4'b1111, 32'hDEAD_BEEF, 32'h0, 0);
        do_access("SB",  1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0,
                  4'b1000, 32'hA5A5_A5A5, 32'h0, 0);
        do_access("SH",  1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 2, 0, 32'h0,
                  4'b1100, 32'hBEEF_BEEF, 32'h0, 2);
        do_access("LB",  1'b0, 3'b000, 32'h0000_2002, 32'h0, 0, 1, 32'h0080_FF00,
                  4'b0100, 32'h0, 32'hFFFF_FF80, 1);
        do_access("LBU", 1'b0, 3'b100, 32'h0000_2002, 32'h0, 0, 1, 32'h0080_FF00,
                  4'b0100, 32'h0, 32'h0000_0080, 1);
        do_access("LB1", 1'b0, 3'b000, 32'h0000_2001, 32'h0, 0, 1, 32'h0000_7F00,
                  4'b0010, 32'h0, 32'h0000_007F, 1);
        do_access("LH",  1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234,
                  4'b1100, 32'h0, 32'hFFFF_8001, 1);
        do_access("LHU", 1'b0, 3'b101, 32'h0000_2000, 32'h0, 0, 1, 32'h8001_1234,
                  4'b0011, 32'h0, 32'h0000_1234, 1);
        do_access("LW",  1'b0, 3'b010, 32'h0000_2004, 32'h0, 3, 2, 32'hCAFE_F00D,
                  4'b1111, 32'h0, 32'hCAFE_F00D, 5);

        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b001; i_addr = 32'h0000_2001;
        i_dmem_ready = 1'b1;
        @(negedge i_clk);
        chk("LH mis flag",  {31'd0, o_misaligned}, 32'd1);
        chk("LH mis req",   {31'd0, o_dmem_req}, 32'd0);
        chk("LH mis stall", {31'd0, o_stall}, 32'd0);
        chk("LH mis valid", {31'd0, o_valid}, 32'd1);
        next_cycle();
        i_mem_read = 1'b0; i_mem_write = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_1002;
        @(negedge i_clk);
        chk("SW mis flag",  {31'd0, o_misaligned}, 32'd1);
        chk("SW mis req",   {31'd0, o_dmem_req}, 32'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // r=0: accepted then no response; r=1: never accepted.
        for (int r = 0; r < 2; r++) begin
            int err_cyc = -1;
            i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_3000;
            i_dmem_ready = (r == 0);
            for (int cyc = 0; cyc < 20; cyc++) begin
                @(negedge i_clk);
                if (o_bus_err) begin
                    err_cyc = cyc;
                    chk("TO valid", {31'd0, o_valid}, 32'd1);
                    chk("TO stall", {31'd0, o_stall}, 32'd0);
                    chk("TO data",  o_mem_data_out, 32'd0);
                    break;
                end
                next_cycle();
            end
            chk(r == 0 ? "TO wait cycle" : "TO req cycle", err_cyc, 32'd8);
            next_cycle();
            idle_inputs();
            next_cycle();
        end

        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_4000;
        i_dmem_ready = 1'b1;
        next_cycle();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hFFFF_FFFF;
        i_rst         = 1'b0;
        #1;
        chk("RW stall",  {31'd0, o_stall}, 32'd0);
        chk("RW valid",  {31'd0, o_valid}, 32'd0);
        chk("RW req",    {31'd0, o_dmem_req}, 32'd0);
        chk("RW data",   o_mem_data_out, 32'd0);
        chk("RW rdata",  o_dmem_rdata, 32'd0);
        chk("RW addr",   o_dmem_addr, 32'd0);
        next_cycle();
        idle_inputs();
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_addr  = 32'h0000_5000;
        @(negedge i_clk);
        chk("NOP valid", {31'd0, o_valid}, 32'd1);
        chk("NOP stall", {31'd0, o_stall}, 32'd0);
        chk("NOP data",  o_mem_data_out, 32'd0);
        chk("NOP req",   {31'd0, o_dmem_req}, 32'd0);
        next_cycle();
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It issues data-memory requests over a ready/valid handshake and aligns store data and byte masks. It extracts and sign- or zero-extends load data, and stalls the pipeline until each access completes. Its outputs feed the MEM/WB register's mem-data, valid and dmem trace inputs.

## Interface
- WAIT_LIMIT, 255: maximum cycles spent in REQ+WAIT before a bus error is declared.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  EX/MEM slot holds a real instruction.
- i_mem_read, i_mem_write  in  1 each  load / store instruction; never both high.
- i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- i_addr  in  32  effective byte address from EX.
- i_store_data  in  32  rs2 value; the low byte or halfword is used for SB/SH.
- o_dmem_req  out  1  request valid.
- i_dmem_ready  in  1  memory accepts the request this cycle.
- o_dmem_addr  out  32  word address {i_addr[31:2],2'b00}.
- o_dmem_wen, o_dmem_ren  out  1 each  write / read request.
- o_dmem_mask  out  4  byte enables.
- o_dmem_wdata  out  32  lane-replicated store data.
- i_dmem_rvalid  in  1  one-cycle read response strobe.
- i_dmem_rdata  in  32  read word; valid only with i_dmem_rvalid.
- o_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- o_valid  out  1  instruction completes this cycle; goes to MEM/WB i_valid.
- o_mem_data_out  out  32  extended load result; 0 for non-loads.
- o_dmem_rdata  out  32  raw response word, for trace.
- o_misaligned  out  1  misaligned access detected; no request is issued.
- o_bus_err  out  1  WAIT_LIMIT exceeded; routed to halt.

## Operation
- FSM states are IDLE, REQ and WAIT. The cycle counter is cleared on every entry to IDLE.
- Misalignment rule: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - o_misaligned=1 and o_valid=1 for that cycle.
  - No request, no stall, FSM stays IDLE.
- Non-memory instruction (i_valid=1, neither read nor write): passes through in zero cycles with o_valid=1, o_stall=0 and o_mem_data_out=0.
- IDLE with an aligned access:
  - o_dmem_req=1 combinationally.
  - If i_dmem_ready=1: a store completes now (o_valid=1, o_stall=0); a load goes to WAIT with o_stall=1.
  - If i_dmem_ready=0: go to REQ with o_stall=1.
- REQ: hold o_dmem_req and all request fields stable, o_stall=1. When i_dmem_ready=1, behave as in the IDLE accept case.
- WAIT: o_dmem_req=0, o_stall=1.
  - When i_dmem_rvalid=1, drive the result combinationally, o_valid=1, o_stall=0, and go to IDLE.
  - rvalid in IDLE or REQ is ignored.
- Store lanes:
  - SB: mask=1<<addr[1:0], wdata={4{byte}}.
  - SH: mask=0011 if addr[1]=0, else 1100; wdata={2{half}}.
  - SW: mask=1111.
- Loads drive the same mask pattern for trace.
- Load extract: select the byte lane addr[1:0] or halfword lane addr[1], then sign-extend (B/H) or zero-extend (BU/HU).
- Timeout:
  - The counter increments each cycle in REQ or WAIT.
  - When it reaches WAIT_LIMIT: o_bus_err=1, o_valid=1, o_mem_data_out=0, o_stall=0, go to IDLE.
  - Memory never responds after a timeout; the error is fatal.
- Upstream holds i_* stable while o_stall=1.

## Timing
- Reset (i_rst=0):
  - State goes to IDLE and the counter to 0.
  - o_dmem_req, o_stall, o_valid, o_misaligned and o_bus_err are forced to 0; data outputs are 0.
- Reset mid-access abandons the transaction; the memory is reset on the same i_rst.
- Store with ready high: 0 stall cycles.
- Load with request accepted at cycle N and rvalid at N+k: k stall cycles, result at cycle N+k. A zero-wait memory (k=1) costs 1 stall.
- Each ready-low cycle adds 1 stall cycle.
- Timeout fires at cycle WAIT_LIMIT after leaving IDLE.

## Structure
- Package riscv_mem_pkg holds:
  - the funct3 size constants;
  - the FSM state enum (IDLE/REQ/WAIT);
  - the misalignment predicate.
- Sub-module lsu_align: combinational store-lane/mask generation and load extract/extend, shared with the trace checker. The FSM and counter live in mem_stage_lsu.

## Test plan
- SW, addr 0x1000, data 0xDEADBEEF, ready=1 → same cycle: req, mask 1111, wdata 0xDEADBEEF, o_valid=1, o_stall=0.
- SB, addr 0x1003, data 0x000000A5 → dmem_addr 0x1000, mask 1000, wdata 0xA5A5A5A5.
- LB, addr 0x2002, ready=1, rvalid after 1 cycle with rdata 0x0080FF00 → exactly one stall cycle, o_mem_data_out 0xFFFFFF80. The same access with LBU gives 0x00000080.
- LH, addr 0x2001 → o_misaligned=1, o_dmem_req=0, no stall.
- LW with ready low for 3 cycles, then rvalid 2 cycles after accept → 5 stall cycles and request fields stable throughout. No rvalid with WAIT_LIMIT=8 → o_bus_err at cycle 8, data 0.
- Reset asserted while in WAIT → all outputs 0 immediately. After release, a non-memory instruction passes through with o_valid=1 and no stall.
